regfile_operand_fetch: RTL and testbench

Requester-side companion to the core register file: accepts decoded source/destination register indices and issues read requests on the register file's two read ports. It collects the registered read data one cycle later and presents both operands to the execute stage on a valid/ready handshake. It also forwards write-back to the register file's write port, bypasses same-window write-back data over stale reads, and keeps a pending-destination scoreboard so operands are never read before their producer writes back.

---
 rtl/regfile_operand_fetch.sv | 116 +++++++++++
 tb/tb_regfile_operand_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: issues register-file reads, bypasses write-back, holds operands for execute behind a pending-destination scoreboard
module regfile_operand_fetch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DEPTH-1:0] req_rs1,
  input  logic [DEPTH-1:0] req_rs2,
  input  logic             req_rs1_used,
  input  logic             req_rs2_used,
  input  logic [DEPTH-1:0] req_rd,
  input  logic             req_rd_used,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_data_1,
  output logic [WIDTH-1:0] op_data_2,
  input  logic             wb_enable,
  input  logic [DEPTH-1:0] wb_index,
  input  logic [WIDTH-1:0] wb_data,
  output logic             rf_read_enable_1,
  output logic             rf_read_enable_2,
  output logic [DEPTH-1:0] rf_read_index_1,
  output logic [DEPTH-1:0] rf_read_index_2,
  input  logic [WIDTH-1:0] rf_read_data_1,
  input  logic [WIDTH-1:0] rf_read_data_2,
  output logic             rf_write_enable,
  output logic [DEPTH-1:0] rf_write_index,
  output logic [WIDTH-1:0] rf_write_data
);
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  localparam int N = 1 << DEPTH;
  state_t           state_q, state_d;
  logic [DEPTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic             used1_q, used1_d, used2_q, used2_d;
  logic             byp1_q, byp1_d, byp2_q, byp2_d;
  logic [WIDTH-1:0] bd1_q, bd1_d, bd2_q, bd2_d;
  logic             op_valid_q, op_valid_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             hazard, accept;
  always_comb begin
    hazard = (req_rs1_used && req_rs1 != '0 && pend_q[req_rs1] && !(wb_enable && wb_index == req_rs1)) ||
             (req_rs2_used && req_rs2 != '0 && pend_q[req_rs2] && !(wb_enable && wb_index == req_rs2)) ||
             (req_rd_used && req_rd != '0 && pend_q[req_rd]);
    req_ready = state_q == IDLE && !hazard && !reset;
    accept = req_valid && req_ready;
    rf_read_enable_1 = accept && req_rs1_used;
    rf_read_enable_2 = accept && req_rs2_used;
    rf_read_index_1 = accept ? req_rs1 : '0;
    rf_read_index_2 = accept ? req_rs2 : '0;
    rf_write_enable = wb_enable && wb_index != '0;
    rf_write_index = wb_index;
    rf_write_data = wb_data;
    state_d = (state_q == IDLE && accept) ? CAPTURE :
              state_q == CAPTURE ? HOLD :
              (state_q == HOLD && op_ready) ? IDLE : state_q;
    rs1_d = accept ? req_rs1 : rs1_q;
    rs2_d = accept ? req_rs2 : rs2_q;
    used1_d = accept ? req_rs1_used : used1_q;
    used2_d = accept ? req_rs2_used : used2_q;
    byp1_d = accept ? wb_enable && wb_index == req_rs1 : byp1_q;
    byp2_d = accept ? wb_enable && wb_index == req_rs2 : byp2_q;
    bd1_d = accept ? wb_data : bd1_q;
    bd2_d = accept ? wb_data : bd2_q;
    op1_d = op1_q;
    op2_d = op2_q;
    op_valid_d = op_valid_q;
    if (state_q == CAPTURE) begin
      op1_d = (!used1_q || rs1_q == '0) ? '0 : (wb_enable && wb_index == rs1_q) ? wb_data : byp1_q ? bd1_q : rf_read_data_1;
      op2_d = (!used2_q || rs2_q == '0) ? '0 : (wb_enable && wb_index == rs2_q) ? wb_data : byp2_q ? bd2_q : rf_read_data_2;
      op_valid_d = 1'b1;
    end
    if (state_q == HOLD && op_ready) op_valid_d = 1'b0;
    pend_d = pend_q;
    if (wb_enable) pend_d[wb_index] = 1'b0;
    if (accept && req_rd_used && req_rd != '0) pend_d[req_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      used1_q <= 1'b0;
      used2_q <= 1'b0;
      byp1_q <= 1'b0;
      byp2_q <= 1'b0;
      bd1_q <= '0;
      bd2_q <= '0;
      op_valid_q <= 1'b0;
      op1_q <= '0;
      op2_q <= '0;
      pend_q <= '0;
    end else begin
      state_q <= state_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      used1_q <= used1_d;
      used2_q <= used2_d;
      byp1_q <= byp1_d;
      byp2_q <= byp2_d;
      bd1_q <= bd1_d;
      bd2_q <= bd2_d;
      op_valid_q <= op_valid_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      pend_q <= pend_d;
    end
  end
  assign op_valid = op_valid_q;
  assign op_data_1 = op1_q;
  assign op_data_2 = op2_q;
endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb_regfile_operand_fetch: directed scoreboard bench for regfile_operand_fetch
module tb_regfile_operand_fetch;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic        req_rs1_used = 1'b0, req_rs2_used = 1'b0, req_rd_used = 1'b0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [31:0] op_data_1, op_data_2;
  logic        wb_enable = 1'b0;
  logic [4:0]  wb_index = '0;
  logic [31:0] wb_data = '0;
  logic        rf_read_enable_1, rf_read_enable_2;
  logic [4:0]  rf_read_index_1, rf_read_index_2;
  logic [31:0] rf_read_data_1, rf_read_data_2;
  logic        rf_write_enable;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_data;
  logic [31:0] regs [32];
  logic [63:0] sb [$];
  int          total = 0;
  int          passed = 0;
  int          w;
  regfile_operand_fetch #(.WIDTH(32), .DEPTH(5)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rs1_used(req_rs1_used), .req_rs2_used(req_rs2_used),
    .req_rd(req_rd), .req_rd_used(req_rd_used),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_data_1(op_data_1), .op_data_2(op_data_2),
    .wb_enable(wb_enable), .wb_index(wb_index), .wb_data(wb_data),
    .rf_read_enable_1(rf_read_enable_1), .rf_read_enable_2(rf_read_enable_2),
    .rf_read_index_1(rf_read_index_1), .rf_read_index_2(rf_read_index_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .rf_write_enable(rf_write_enable), .rf_write_index(rf_write_index),
    .rf_write_data(rf_write_data)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[3] <= 32'h11;
      regs[4] <= 32'h22;
      regs[7] <= 32'h1;
      rf_read_data_1 <= '0;
      rf_read_data_2 <= '0;
    end else begin
      if (rf_read_enable_1) rf_read_data_1 <= regs[rf_read_index_1];
      if (rf_read_enable_2) rf_read_data_2 <= regs[rf_read_index_2];
      if (rf_write_enable) regs[rf_write_index] <= rf_write_data;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask
  task automatic set_wb(input logic en, input logic [4:0] idx, input logic [31:0] d);
    wb_enable = en;
    wb_index = idx;
    wb_data = d;
  endtask
  task automatic issue(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic ud, input logic [31:0] e1, input logic [31:0] e2,
                       input bit push, output int waits);
    bit done = 0;
    req_rs1 = r1; req_rs1_used = u1; req_rs2 = r2; req_rs2_used = u2;
    req_rd = rd; req_rd_used = ud; req_valid = 1'b1;
    waits = 0;
    while (!done) begin
      @(negedge CLK);
      if (req_ready) begin
        done = 1;
        chk("rd_en1", {31'b0, rf_read_enable_1}, {31'b0, u1});
        chk("rd_en2", {31'b0, rf_read_enable_2}, {31'b0, u2});
        chk("rd_idx1", {27'b0, rf_read_index_1}, {27'b0, r1});
        chk("rd_idx2", {27'b0, rf_read_index_2}, {27'b0, r2});
        if (push) sb.push_back({e1, e2});
      end else begin
        waits++;
        if (waits > 40) begin
          chk("accept_timeout", 32'd0, 32'd1);
          done = 1;
        end
      end
      nxt();
    end
    req_valid = 1'b0;
  endtask
  always @(negedge CLK) begin
    if (!reset && op_valid && op_ready) begin
      if (sb.size() == 0) chk("unexpected_op", 32'd1, 32'd0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("op_data_1", op_data_1, e[63:32]);
        chk("op_data_2", op_data_2, e[31:0]);
      end
    end
  end
  initial begin
    nxt();
    @(negedge CLK);
    chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
    chk("rst_op1", op_data_1, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    nxt();
    reset = 1'b0;
    issue(5'd3, 1, 5'd4, 1, 5'd0, 0, 32'h11, 32'h22, 1, w);
    @(negedge CLK); chk("t1_valid_t1", {31'b0, op_valid}, 32'd0); nxt();
    @(negedge CLK); chk("t1_valid_t2", {31'b0, op_valid}, 32'd1); nxt();
    @(negedge CLK); chk("t1_ready_t3", {31'b0, req_ready}, 32'd1); nxt();
    issue(5'd0, 1, 5'd9, 0, 5'd0, 0, 32'h0, 32'h0, 1, w);
    chk("t2_no_stall", w, 32'd0);
    nxt(); nxt();
    op_ready = 1'b0;
    issue(5'd3, 1, 5'd4, 1, 5'd5, 1, 32'h11, 32'h22, 1, w);
    nxt();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t3_hold_valid", {31'b0, op_valid}, 32'd1);
      chk("t3_hold_op1", op_data_1, 32'h11);
      chk("t3_hold_op2", op_data_2, 32'h22);
      nxt();
    end
    op_ready = 1'b1;
    @(negedge CLK); nxt();
    req_rs1 = 5'd5; req_rs1_used = 1; req_rs2 = 5'd0; req_rs2_used = 0;
    req_rd = 5'd0; req_rd_used = 0; req_valid = 1'b1;
    @(negedge CLK); chk("t3_stall_a", {31'b0, req_ready}, 32'd0); nxt();
    @(negedge CLK); chk("t3_stall_b", {31'b0, req_ready}, 32'd0); nxt();
    set_wb(1, 5'd5, 32'hAB);
    @(negedge CLK);
    chk("t3_wb_accept", {31'b0, req_ready}, 32'd1);
    chk("t3_rd_en1", {31'b0, rf_read_enable_1}, 32'd1);
    if (req_ready) sb.push_back({32'hAB, 32'h0});
    nxt();
    req_valid = 1'b0;
    set_wb(0, 5'd0, 32'h0);
    nxt(); nxt(); nxt();
    issue(5'd7, 1, 5'd0, 0, 5'd0, 0, 32'h99, 32'h0, 1, w);
    set_wb(1, 5'd7, 32'h99); nxt(); set_wb(0, 5'd0, 32'h0); nxt(); nxt();
    set_wb(1, 5'd7, 32'h1); nxt(); set_wb(0, 5'd0, 32'h0);
    set_wb(1, 5'd7, 32'h99);
    issue(5'd7, 1, 5'd0, 0, 5'd0, 0, 32'h99, 32'h0, 1, w);
    set_wb(0, 5'd0, 32'h0); nxt(); nxt();
    set_wb(1, 5'd7, 32'h1); nxt(); set_wb(0, 5'd0, 32'h0);
    issue(5'd7, 1, 5'd0, 0, 5'd0, 0, 32'h1, 32'h0, 1, w);
    set_wb(1, 5'd8, 32'h55); nxt(); set_wb(0, 5'd0, 32'h0); nxt(); nxt();
    issue(5'd0, 0, 5'd0, 0, 5'd6, 1, 32'h0, 32'h0, 1, w);
    nxt(); nxt();
    req_rs1 = 5'd0; req_rs1_used = 0; req_rs2 = 5'd0; req_rs2_used = 0;
    req_rd = 5'd6; req_rd_used = 1; req_valid = 1'b1;
    @(negedge CLK); chk("t5_waw_stall", {31'b0, req_ready}, 32'd0); nxt();
    set_wb(1, 5'd0, 32'h5);
    @(negedge CLK);
    chk("t5_wb0_no_write", {31'b0, rf_write_enable}, 32'd0);
    chk("t5_waw_stall_b", {31'b0, req_ready}, 32'd0);
    nxt();
    set_wb(1, 5'd9, 32'h77);
    @(negedge CLK);
    chk("t5_wb9_write", {31'b0, rf_write_enable}, 32'd1);
    chk("t5_wb9_index", {27'b0, rf_write_index}, 32'd9);
    chk("t5_wb9_data", rf_write_data, 32'h77);
    nxt();
    set_wb(0, 5'd0, 32'h0);
    req_valid = 1'b0;
    issue(5'd3, 1, 5'd0, 0, 5'd10, 1, 32'h0, 32'h0, 0, w);
    reset = 1'b1;
    @(negedge CLK); chk("t6_rst_ready", {31'b0, req_ready}, 32'd0); nxt();
    reset = 1'b0;
    @(negedge CLK); chk("t6_rst_valid", {31'b0, op_valid}, 32'd0); nxt();
    issue(5'd0, 0, 5'd0, 0, 5'd6, 1, 32'h0, 32'h0, 1, w);
    chk("t6_rd6_immediate", w, 32'd0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) nxt();
    chk("drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
